counter_pipe: RTL

Parametrised up/down counter with synchronous clear, parallel load, programmable modulo limit, wrap or saturate mode, and a configurable output pipeline. It generalises the team's fixed 4-bit pipelined counter to arbitrary width and latency and adds direction, load and terminal-count signalling. It serves as a timebase or event-counter primitive for the blocks around it.

---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_pipe_if.sv | 26 ++
 rtl/pipe_delay.sv | 40 ++++
 rtl/counter_pipe.sv | 85 ++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the counter_pipe family
package counter_pkg;

    // SATURATE parameter values
    localparam int CNT_WRAP  = 0;
    localparam int CNT_SAT   = 1;

    // Legal parameter ranges
    localparam int MAX_WIDTH = 32;
    localparam int MAX_PIPE  = 4;

endpackage

// File: rtl/counter_pipe_if.sv
// rtl/counter_pipe_if.sv - control/status bundle between a counter user and counter_pipe
//
// master : drives en, up_dn, clr, load, load_val, limit; receives count_out, tc
// slave  : the counter side (counter_pipe)
interface counter_pipe_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] count_out;
    logic             tc;

    modport master (
        output en, up_dn, clr, load, load_val, limit,
        input  count_out, tc
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, limit,
        output count_out, tc
    );
endinterface

// File: rtl/pipe_delay.sv
// rtl/pipe_delay.sv - DEPTH x DATA_W register chain with async active-low reset
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : data in
//   q     : data out, DEPTH cycles after d (DEPTH = 0 is a pure wire)
module pipe_delay #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        wire unused_clk_rst = &{1'b0, clk, rst_n};
        assign q = d;
    end else begin : g_regs
        logic [DATA_W-1:0] stage [DEPTH];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/counter_pipe.sv
// rtl/counter_pipe.sv - up/down modulo counter with load, clear, wrap/saturate and output pipeline
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   cif   : counter_pipe_if.slave
//           en, up_dn, clr, load, load_val, limit in; count_out, tc out
//           count_out/tc trail the core register by PIPE_STAGES cycles
module counter_pipe
    import counter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 1,
    parameter int SATURATE    = CNT_WRAP
) (
    input  logic           clk,
    input  logic           rst_n,
    counter_pipe_if.slave  cif
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE ||
        (SATURATE != CNT_WRAP && SATURATE != CNT_SAT)) begin : g_bad_param
        $error("counter_pipe: parameter out of range");
    end

    localparam bit SAT_MODE = (SATURATE == CNT_SAT);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH:0]   pipe_q;

    // Priority clr > load > en > hold. tc only marks boundary steps.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (cif.clr) begin
            cnt_d = '0;
        end else if (cif.load) begin
            cnt_d = (cif.load_val > cif.limit) ? cif.limit : cif.load_val;
        end else if (cif.en) begin
            if (cif.up_dn) begin
                // >= so a limit lowered below the count acts as a boundary
                if (cnt_q >= cif.limit) begin
                    cnt_d = SAT_MODE ? cif.limit : '0;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = SAT_MODE ? '0 : cif.limit;
                    tc_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    pipe_delay #(
        .DEPTH  (PIPE_STAGES),
        .DATA_W (WIDTH + 1)
    ) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({cnt_q, tc_q}),
        .q     (pipe_q)
    );

    assign cif.count_out = pipe_q[WIDTH:1];
    assign cif.tc        = pipe_q[0];

endmodule
